// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub/move and address ops take one cycle; MUL is iterative shift-add.
// Define ALU_DIV_EN to build the restoring divider for DIV/REM; otherwise both are rejected.
//
// state | meaning
// IDLE  | waiting for an operation
// MUL   | shift-add iterations, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// DONE  | res/err presented, held until out_ready
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_SUB  = 7'h02;
  localparam logic [6:0] OP_MOV  = 7'h03;
  localparam logic [6:0] OP_MOVI = 7'h04;
  localparam logic [6:0] OP_LDB  = 7'h05;
  localparam logic [6:0] OP_LDW  = 7'h06;
  localparam logic [6:0] OP_STB  = 7'h07;
  localparam logic [6:0] OP_STW  = 7'h08;
  localparam logic [6:0] OP_BEQ  = 7'h09;
  localparam logic [6:0] OP_JUMP = 7'h0A;
  localparam logic [6:0] OP_BZ   = 7'h0B;
  localparam logic [6:0] OP_MUL  = 7'h0C;
`ifdef ALU_DIV_EN
  localparam logic [6:0] OP_DIV  = 7'h0D;
  localparam logic [6:0] OP_REM  = 7'h0E;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             accept;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign err       = err_q;

  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

`ifdef ALU_DIV_EN
  logic             rem_q, rem_d;
  logic [WIDTH:0]   div_r, div_t;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quo_next;

  // acc_q holds the partial remainder (always < divisor); a_q shifts dividend out, quotient in
  assign div_r    = {acc_q, a_q[WIDTH-1]};
  assign div_t    = div_r - {1'b0, b_q};
  assign q_bit    = ~div_t[WIDTH];
  assign rem_next = q_bit ? div_t[WIDTH-1:0] : div_r[WIDTH-1:0];
  assign quo_next = {a_q[WIDTH-2:0], q_bit};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef ALU_DIV_EN
    rem_d   = rem_q;
`endif

    case (state_q)
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          res_d   = mul_sum;
          err_d   = 1'b0;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        acc_d = rem_next;
        a_d   = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          res_d   = rem_q ? rem_next : quo_next;
          err_d   = 1'b0;
        end
      end
`endif
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      cnt_d = '0;
      a_d   = data1;
      b_d   = data2;
      acc_d = '0;
      case (opcode)
        OP_ADD, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_BEQ, OP_JUMP, OP_BZ: begin
          state_d = S_DONE;
          res_d   = data1 + data2;
          err_d   = 1'b0;
        end
        OP_SUB: begin
          state_d = S_DONE;
          res_d   = data1 - data2;
          err_d   = 1'b0;
        end
        OP_MOV, OP_MOVI: begin
          state_d = S_DONE;
          res_d   = data1;
          err_d   = 1'b0;
        end
        OP_MUL: state_d = S_MUL;
`ifdef ALU_DIV_EN
        OP_DIV, OP_REM: begin
          if (data2 == '0) begin
            state_d = S_DONE;
            res_d   = (opcode == OP_REM) ? data1 : '1;
            err_d   = 1'b1;
          end else begin
            state_d = S_DIV;
            rem_d   = (opcode == OP_REM);
          end
        end
`endif
        default: begin
          state_d = S_DONE;
          res_d   = '1;
          err_d   = 1'b1;
        end
      endcase
    end

    // a flush on the final iteration must not leak a partial result into res/err
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef ALU_DIV_EN
      rem_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef ALU_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a monitor pops on each handshake.
// DIV/REM expectations follow ALU_DIV_EN.
module tb_alu_mc;
  localparam int W = 32;

  localparam logic [6:0] OP_ADD  = 7'h01;
  localparam logic [6:0] OP_SUB  = 7'h02;
  localparam logic [6:0] OP_MOV  = 7'h03;
  localparam logic [6:0] OP_MOVI = 7'h04;
  localparam logic [6:0] OP_LDW  = 7'h06;
  localparam logic [6:0] OP_MUL  = 7'h0C;
  localparam logic [6:0] OP_DIV  = 7'h0D;
  localparam logic [6:0] OP_REM  = 7'h0E;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [6:0]   opcode = '0;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res;
  logic         err;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .data1(data1), .data2(data2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           t_acc;
    int           id;
  } item_t;

  item_t sb[$];
  bit    seen = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: latency on first appearance of out_valid, value on handshake
  always @(negedge clk) begin
    if (!rst) seen = 1'b0;
    else if (out_valid) begin
      if (sb.size() == 0) check("unexpected_output", 32'(out_valid), 32'(0));
      else begin
        if (!seen) begin
          seen = 1'b1;
          check($sformatf("latency_%0d", sb[0].id), 32'(cyc - sb[0].t_acc), 32'(sb[0].lat));
        end
        if (out_ready) begin
          check($sformatf("res_%0d", sb[0].id), res, sb[0].res);
          check($sformatf("err_%0d", sb[0].id), 32'(err), 32'(sb[0].err));
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  int next_id = 0;

  // called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input logic exp_err, input int lat,
                       input bit push, output int waited);
    item_t it;
    waited = 0;
    opcode = op; data1 = a; data2 = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'(1));
    else if (push) begin
      it.res = exp_res; it.err = exp_err; it.lat = lat; it.t_acc = cyc; it.id = next_id;
      sb.push_back(it);
    end
    next_id++;
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    opcode = 7'h55;
    data1 = $urandom;
    data2 = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int bad;
    int t0;

    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_res", res, '0);
    check("reset_err", 32'(err), 32'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 1, 1, w);
    idle_in();
    drain();

    issue(OP_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, W + 1, 1, w);
    idle_in();
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (in_ready) bad++;
    end
    check("mul_in_ready_low", 32'(bad), 32'(0));
    drain();

    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, W + 1, 1, w);
    idle_in();
    drain();

`ifdef ALU_DIV_EN
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, W + 1, 1, w);
    idle_in(); drain();
    issue(OP_REM, 32'd100, 32'd7, 32'd2, 1'b0, W + 1, 1, w);
    idle_in(); drain();
    issue(OP_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, W + 1, 1, w);
    idle_in(); drain();
    issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1, w);
    idle_in(); drain();
    issue(OP_REM, 32'd9, 32'd0, 32'd9, 1'b1, 1, 1, w);
    idle_in(); drain();
`else
    issue(OP_DIV, 32'd100, 32'd7, 32'hFFFF_FFFF, 1'b1, 1, 1, w);
    idle_in(); drain();
    issue(OP_REM, 32'd100, 32'd7, 32'hFFFF_FFFF, 1'b1, 1, 1, w);
    idle_in(); drain();
`endif

    // stall with result held, then release together with a new accept
    out_ready = 1'b0;
    issue(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 1, w);
    idle_in();
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || res !== 32'hFFFF_FFFE || in_ready) bad++;
    end
    check("stall_hold", 32'(bad), 32'(0));
    @(posedge clk); #1 out_ready = 1'b1;
    issue(OP_MOV, 32'h0000_1234, 32'hCAFE_0000, 32'h0000_1234, 1'b0, 1, 1, w);
    check("mov_same_cycle_accept", 32'(w), 32'(0));
    idle_in();
    drain();

    // back-to-back single-cycle ops
    t0 = cyc;
    issue(OP_ADD,  32'd1,       32'd2,    32'd3,        1'b0, 1, 1, w);
    issue(OP_SUB,  32'd10,      32'd3,    32'd7,        1'b0, 1, 1, w);
    issue(OP_MOVI, 32'hABCD,    32'hFFFF, 32'hABCD,     1'b0, 1, 1, w);
    issue(OP_LDW,  32'h100,     32'h20,   32'h120,      1'b0, 1, 1, w);
    issue(OP_BAD,  32'd4,       32'd4,    32'hFFFF_FFFF, 1'b1, 1, 1, w);
    check("b2b_cycles", 32'(cyc - t0), 32'(5));
    idle_in();
    drain();

    // flush wins over a same-cycle accept
    opcode = OP_ADD; data1 = 32'd8; data2 = 32'd8; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_prio_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;

    // flush mid-MUL
    issue(OP_MUL, 32'd7, 32'd9, '0, 1'b0, 0, 0, w);
    idle_in();
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'(0));
    check("flush_idle_ready", 32'(in_ready), 32'(1));
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("flush_no_result", 32'(bad), 32'(0));
    @(posedge clk); #1;
    issue(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1, 1, w);
    idle_in();
    drain();

    // asynchronous reset mid-operation
`ifdef ALU_DIV_EN
    issue(OP_DIV, 32'd1000, 32'd3, '0, 1'b0, 0, 0, w);
`else
    issue(OP_MUL, 32'd1000, 32'd3, '0, 1'b0, 0, 0, w);
`endif
    idle_in();
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_res", res, '0);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    issue(OP_ADD, 32'd5, 32'd6, 32'd11, 1'b0, 1, 1, w);
    idle_in();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
